mcpu5_host: RTL and testbench
=============================

// Module: mcpu5_host
// PURPOSE
//  Host-side counterpart of the MCPU5 core: program store and bus sequencer on the far side of the
//  6-in/8-out pad interface. Generates the core clock/reset, samples PC on the high phase, serves
//  the 6-bit instruction, captures ACCU on the low phase of OUT instructions into an output FIFO.
//  Runs entirely on one system clock.
// PARAMETERS
//  HALF_PERIOD  4    system clocks per cpu_clk phase (>=2)
//  RST_CYCLES   2    cpu_clk rising edges with cpu_rst=1 per start
//  FIFO_DEPTH   4    OUT capture FIFO entries (power of 2)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous, active-high reset
//  start        in   1   pulse: reset core and run from PC 0 (IDLE only)
//  stop         in   1   pulse: halt after current cpu_clk period
//  prog_we      in   1   program write strobe (honoured in IDLE only)
//  prog_addr    in   8   program address
//  prog_wdata   in   6   instruction word
//  cpu_out      in   8   core bus: PC while cpu_clk=1, ACCU while cpu_clk=0
//  cpu_clk      out  1   core clock
//  cpu_rst      out  1   core reset
//  cpu_inst     out  6   instruction to core
//  out_valid    out  1   FIFO head valid
//  out_data     out  8   FIFO head (captured ACCU)
//  out_ready    in   1   consumer accepts head when out_valid&out_ready
//  running      out  1   1 in CPU_RST/RUN_HI/RUN_LO/STALL
//  fetch_pc     out  8   last sampled PC
//  cycle_count  out  16  core rising edges since start, saturating at 0xFFFF
// BEHAVIOUR
//  Reset: cpu_clk=0, cpu_rst=1, cpu_inst=0, out_valid=0, out_data=0, running=0, fetch_pc=0,
//   cycle_count=0, FIFO empty, state IDLE. Program RAM (256x6) not reset.
//  Phase counter ph 0..HALF_PERIOD-1; every phase lasts exactly HALF_PERIOD clk cycles.
//  IDLE: cpu_clk=0, cpu_rst=1; prog_we writes RAM; start -> CPU_RST, ph=0, FIFO flushed,
//   cycle_count=0. start and stop both set in IDLE: start wins.
//  CPU_RST: cpu_rst=1, cpu_inst=0, cpu_clk toggles low/high; after RST_CYCLES rising edges the
//   high phase following the last edge is RUN_HI; cpu_rst drops at its first cycle (ph=0).
//  RUN_HI (cpu_clk=1): at ph==HALF_PERIOD-2 register fetch_pc<=cpu_out, cpu_inst<=RAM[cpu_out];
//   inst changes only while cpu_clk=1 (core STA latch closed). End of phase -> RUN_LO.
//  RUN_LO (cpu_clk=0): cpu_inst held. At ph==HALF_PERIOD-1: if cpu_inst==OP_OUT (6'b111001)
//   push cpu_out; FIFO full -> STALL instead of rising. Else -> RUN_HI, cycle_count+1; if stop
//   seen during this period -> IDLE (cpu_clk stays 0, no further edge).
//  STALL: cpu_clk held 0, inst held; each cycle retry push; on success -> RUN_HI next cycle
//   (or IDLE if stop pending). Push and pop in same cycle on full FIFO: pop first, push succeeds.
//  stop pulses latched until acted on; stop in CPU_RST honoured at end of reset period.
//  FIFO: first-word fall-through; pop on out_valid&out_ready; empty->out_valid=0.
//  rst mid-run: immediate return to reset values; cpu_rst asserted in the same cycle.
//  prog_we outside IDLE ignored; addresses wrap at 8 bits by construction.
// STRUCTURE
//  Package mcpu5_pkg: OP_OUT, OP_STA, OP_JCC opcode constants; state enum
//   {IDLE, CPU_RST, RUN_HI, RUN_LO, STALL}.
//  Sub-module mcpu5_out_fifo (8-bit x FIFO_DEPTH, sync rst, push/pop/full/empty).
//  Program RAM inferred in-line, async read.
// TESTING (bench instantiates the MCPU5 core wired to this block)
//  Load 0:010101(LDI 5),1:111001(OUT),2:000000(JCC 0); start, out_ready=1 -> out_data 0x05
//   repeated, fetch_pc sequence 0,1,2,0,...
//  Same program, out_ready=0 -> 4 pushes then STALL, cpu_clk low; raise out_ready -> resumes,
//   no value lost or duplicated.
//  stop mid-RUN_HI -> period completes, cpu_clk ends low, IDLE, cycle_count frozen.
//  prog_we while running -> RAM unchanged (read back after stop matches original).
//  rst asserted in RUN_LO -> next cycle cpu_rst=1, cpu_clk=0, out_valid=0, running=0.
//  Check cpu_inst never changes while cpu_clk=0 and each phase is HALF_PERIOD cycles.

Source files
------------

// File: rtl/mcpu5_pkg.sv
// Shared definitions for the MCPU5 host: opcodes, sequencer states and a small helper.
package mcpu5_pkg;

  // Major opcode field, inst[5:4]
  typedef enum logic [1:0] {
    OP_JCC = 2'b00,
    OP_LDI = 2'b01,
    OP_STA = 2'b10,
    OP_ALU = 2'b11
  } major_op_t;

  // The complete OUT instruction word; ACCU is captured when it is executed
  localparam logic [5:0] OP_OUT = 6'b111001;

  typedef enum logic [2:0] {
    IDLE,
    CPU_RST,
    RUN_HI,
    RUN_LO,
    STALL
  } state_t;

  function automatic logic is_out(input logic [5:0] inst);
    return inst == OP_OUT;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mcpu5_out_fifo.sv
// First-word fall-through capture FIFO for ACCU values. A push into a full FIFO
// succeeds when a pop happens in the same cycle (the pop frees the slot first).
module mcpu5_out_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  // Pointer update; an extra wrap bit tells full from empty
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mcpu5_host.sv
// Host-side sequencer for the MCPU5 core: generates cpu_clk/cpu_rst, serves
// instructions from a 256x6 program RAM on the high phase and captures ACCU into
// an output FIFO on the low phase of OUT instructions. cycle_count counts every
// cpu_clk rising edge since start, reset-period edges included.
module mcpu5_host
  import mcpu5_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int RST_CYCLES  = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        prog_we,
  input  logic [7:0]  prog_addr,
  input  logic [5:0]  prog_wdata,
  input  logic [7:0]  cpu_out,
  output logic        cpu_clk,
  output logic        cpu_rst,
  output logic [5:0]  cpu_inst,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        running,
  output logic [7:0]  fetch_pc,
  output logic [15:0] cycle_count
);

  localparam int PW = $clog2(HALF_PERIOD);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] PH_FETCH = PW'(HALF_PERIOD - 2);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  state_t        state;
  logic [PW-1:0] ph;
  logic [RW-1:0] rst_edges;
  logic          stop_pend;
  logic          stop_seen;
  logic [5:0]    prog_mem [256];

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push_ok;
  logic push_try;
  logic push;
  logic flush;

  assign running   = (state != IDLE);
  assign out_valid = !fifo_empty;
  assign pop       = !fifo_empty && out_ready;
  assign push_ok   = !fifo_full || pop;
  assign push_try  = ((state == RUN_LO) && (ph == PH_LAST) && is_out(cpu_inst)) || (state == STALL);
  assign push      = push_try && push_ok;
  assign flush     = (state == IDLE) && start;
  assign stop_seen = stop_pend || stop;

  mcpu5_out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (cpu_out),
    .pop       (pop),
    .head      (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Program RAM: writable only while the core is idle, read asynchronously by PC
  always_ff @(posedge clk) begin
    if (state == IDLE && prog_we) prog_mem[prog_addr] <= prog_wdata;
  end

  // Bus sequencer: phase timing, core clock/reset, fetch and capture control
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ph          <= '0;
      rst_edges   <= '0;
      stop_pend   <= 1'b0;
      cpu_clk     <= 1'b0;
      cpu_rst     <= 1'b1;
      cpu_inst    <= '0;
      fetch_pc    <= '0;
      cycle_count <= '0;
    end else begin
      // Latch stop until the sequencer acts on it; later clears below take priority
      if (stop && state != IDLE) stop_pend <= 1'b1;

      case (state)
        IDLE: begin
          cpu_clk   <= 1'b0;
          cpu_rst   <= 1'b1;
          stop_pend <= 1'b0;
          if (start) begin
            state       <= CPU_RST;
            ph          <= '0;
            rst_edges   <= '0;
            cpu_inst    <= '0;
            cycle_count <= '0;
          end
        end

        CPU_RST: begin
          cpu_rst  <= 1'b1;
          cpu_inst <= '0;
          if (ph == PH_LAST) begin
            ph <= '0;
            if (cpu_clk) begin
              cpu_clk <= 1'b0;
            end else if (rst_edges == RST_LAST && stop_seen) begin
              // Stop during reset: skip the final edge and park the core low
              state     <= IDLE;
              stop_pend <= 1'b0;
            end else begin
              cpu_clk     <= 1'b1;
              rst_edges   <= rst_edges + 1'b1;
              cycle_count <= sat_inc16(cycle_count);
              if (rst_edges == RST_LAST) state <= RUN_HI;
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end

        RUN_HI: begin
          // Released one cycle after the last reset edge so the core sees reset held across it
          cpu_rst <= 1'b0;
          if (ph == PH_FETCH) begin
            fetch_pc <= cpu_out;
            cpu_inst <= prog_mem[cpu_out];
          end
          if (ph == PH_LAST) begin
            ph      <= '0;
            cpu_clk <= 1'b0;
            state   <= RUN_LO;
          end else begin
            ph <= ph + 1'b1;
          end
        end

        RUN_LO: begin
          if (ph == PH_LAST) begin
            ph <= '0;
            if (is_out(cpu_inst) && !push_ok) begin
              state <= STALL;
            end else if (stop_seen) begin
              state     <= IDLE;
              cpu_rst   <= 1'b1;
              stop_pend <= 1'b0;
            end else begin
              state       <= RUN_HI;
              cpu_clk     <= 1'b1;
              cycle_count <= sat_inc16(cycle_count);
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end

        STALL: begin
          // The push is retried every cycle; the clock rises only once it lands
          ph <= '0;
          if (push_ok) begin
            if (stop_seen) begin
              state     <= IDLE;
              cpu_rst   <= 1'b1;
              stop_pend <= 1'b0;
            end else begin
              state       <= RUN_HI;
              cpu_clk     <= 1'b1;
              cycle_count <= sat_inc16(cycle_count);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu5_host.sv
// Directed bench for mcpu5_host with a small behavioural MCPU5 core attached.
module tb_mcpu5_host;
  import mcpu5_pkg::*;

  localparam int HP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [5:0]  prog_wdata = '0;
  logic [7:0]  cpu_out;
  logic        cpu_clk;
  logic        cpu_rst;
  logic [5:0]  cpu_inst;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        running;
  logic [7:0]  fetch_pc;
  logic [15:0] cycle_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mcpu5_host #(.HALF_PERIOD(HP), .RST_CYCLES(2), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_wdata  (prog_wdata),
    .cpu_out     (cpu_out),
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .cpu_inst    (cpu_inst),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .running     (running),
    .fetch_pc    (fetch_pc),
    .cycle_count (cycle_count)
  );

  // Behavioural core: carry is never set here, so JCC always jumps (absolute target)
  logic [7:0] core_pc = '0;
  logic [7:0] core_accu = '0;
  always @(posedge cpu_clk) begin
    if (cpu_rst) begin
      core_pc   <= '0;
      core_accu <= '0;
    end else begin
      case (major_op_t'(cpu_inst[5:4]))
        OP_JCC:  core_pc <= {4'h0, cpu_inst[3:0]};
        OP_LDI:  begin core_accu <= {{4{cpu_inst[3]}}, cpu_inst[3:0]}; core_pc <= core_pc + 8'd1; end
        OP_STA:  core_pc <= core_pc + 8'd1;
        default: core_pc <= core_pc + 8'd1;
      endcase
    end
  end
  assign cpu_out = cpu_clk ? core_pc : core_accu;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Continuous monitors: phase lengths, instruction stability on low phase, fetch_pc trace
  int         ph_cnt = 0;
  logic       prev_clk = 1'b0;
  logic       prev_run = 1'b0;
  logic [5:0] prev_inst = '0;
  bit         mon_en = 1'b0;
  bit         allow_long = 1'b0;
  bit         rec_fpc = 1'b0;
  logic [7:0] fpc_q [$];

  always @(negedge clk) begin
    if (mon_en && running && prev_run && !cpu_clk && !prev_clk)
      check("inst_stable_low", cpu_inst, prev_inst);
    if (!running) begin
      ph_cnt = 0;
    end else if (cpu_clk != prev_clk) begin
      if (mon_en) begin
        if (prev_clk)         check("hi_len", 16'(ph_cnt), 16'(HP));
        else if (!allow_long) check("lo_len", 16'(ph_cnt), 16'(HP));
        else                  check("lo_len_min", {15'd0, ph_cnt >= HP}, 16'd1);
      end
      if (prev_clk && !cpu_clk && rec_fpc) fpc_q.push_back(fetch_pc);
      ph_cnt = 1;
    end else begin
      ph_cnt++;
    end
    prev_clk  = cpu_clk;
    prev_run  = running;
    prev_inst = cpu_inst;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic prog(input logic [7:0] a, input logic [5:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_rst_release(output int n);
    n = 0;
    while (cpu_rst !== 1'b0 && n < 300) begin @(negedge clk); n++; end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 400) begin @(negedge clk); n++; end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (running !== 1'b0 && n < 300) begin @(negedge clk); n++; end
  endtask

  initial begin
    int n;
    int extra;
    int low_run;
    logic [15:0] c0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cpu_clk", {15'd0, cpu_clk}, 16'd0);
    check("rst_cpu_rst", {15'd0, cpu_rst}, 16'd1);
    check("rst_cpu_inst", {10'd0, cpu_inst}, 16'd0);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_out_data", {8'd0, out_data}, 16'd0);
    check("rst_running", {15'd0, running}, 16'd0);
    check("rst_fetch_pc", {8'd0, fetch_pc}, 16'd0);
    check("rst_cycle_count", cycle_count, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // Program A: LDI 5 / OUT / JCC 0
    prog(8'd0, 6'b010101);
    prog(8'd1, 6'b111001);
    prog(8'd2, 6'b000000);

    // Free-running with consumer ready
    out_ready = 1'b1;
    mon_en = 1'b1;
    pulse_start();
    check("start_running", {15'd0, running}, 16'd1);
    check("start_cpu_rst", {15'd0, cpu_rst}, 16'd1);
    check("start_cpu_clk", {15'd0, cpu_clk}, 16'd0);
    wait_rst_release(n);
    check("rst_release", {15'd0, cpu_rst}, 16'd0);
    check("reset_edges", cycle_count, 16'd2);
    rec_fpc = 1'b1;
    prog(8'd0, 6'b010111);  // LDI 7 while running: must be ignored
    for (int k = 0; k < 3; k++) begin
      wait_valid(n);
      check("a_out_valid", {15'd0, out_valid}, 16'd1);
      check("a_out_data", {8'd0, out_data}, 16'h0005);
      @(negedge clk);
    end
    rec_fpc = 1'b0;
    check("fetch_pc_count", {15'd0, fpc_q.size() >= 6}, 16'd1);
    for (int i = 0; i < 6; i++)
      check("fetch_pc_seq", (i < fpc_q.size()) ? {8'd0, fpc_q[i]} : 16'hEEEE, 16'(i % 3));

    // Stop during the high phase: period completes, no further edge
    n = 0;
    while (!(cpu_clk === 1'b1 && cpu_rst === 1'b0) && n < 100) begin @(negedge clk); n++; end
    c0 = cycle_count;
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    wait_idle(n);
    check("stop_idle", {15'd0, running}, 16'd0);
    check("stop_latency", {15'd0, n <= 2 * HP}, 16'd1);
    check("stop_cpu_clk", {15'd0, cpu_clk}, 16'd0);
    check("stop_count", cycle_count, c0);
    repeat (20) @(negedge clk);
    check("idle_count_frozen", cycle_count, c0);
    check("idle_cpu_clk", {15'd0, cpu_clk}, 16'd0);
    check("idle_cpu_rst", {15'd0, cpu_rst}, 16'd1);

    // Restart: RAM must still hold LDI 5 at address 0
    pulse_start();
    wait_valid(n);
    check("ram_unchanged", {8'd0, out_data}, 16'h0005);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    wait_idle(n);
    check("stop2_idle", {15'd0, running}, 16'd0);

    // Program B: emit 1..6 then spin, consumer stalled
    for (int i = 0; i < 6; i++) begin
      prog(8'(2 * i), {2'b01, 4'(i + 1)});
      prog(8'(2 * i + 1), OP_OUT);
    end
    prog(8'd12, 6'b001100);
    out_ready = 1'b0;
    allow_long = 1'b1;
    pulse_start();
    n = 0; low_run = 0;
    while (low_run < 3 * HP && n < 1000) begin
      @(negedge clk); n++;
      low_run = (running && !cpu_clk) ? low_run + 1 : 0;
    end
    check("stall_seen", {15'd0, low_run >= 3 * HP}, 16'd1);
    c0 = cycle_count;
    check("stall_head", {8'd0, out_data}, 16'h0001);
    repeat (30) @(negedge clk);
    check("stall_cpu_clk", {15'd0, cpu_clk}, 16'd0);
    check("stall_running", {15'd0, running}, 16'd1);
    check("stall_count_frozen", cycle_count, c0);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_valid(n);
      check("b_out_data", {8'd0, out_data}, 16'(k + 1));
      @(negedge clk);
    end
    extra = 0;
    repeat (100) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("b_no_extra", 16'(extra), 16'd0);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    wait_idle(n);
    check("stop3_idle", {15'd0, running}, 16'd0);
    allow_long = 1'b0;

    // start and stop together in IDLE: start wins and stop is not remembered
    start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
    check("start_wins", {15'd0, running}, 16'd1);
    repeat (12 * HP) @(negedge clk);
    check("start_wins_still", {15'd0, running}, 16'd1);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    wait_idle(n);
    check("stop4_idle", {15'd0, running}, 16'd0);

    // Synchronous reset during a low phase with data in the FIFO
    out_ready = 1'b0;
    pulse_start();
    wait_rst_release(n);
    wait_valid(n);
    n = 0;
    while (!(cpu_clk === 1'b0 && running === 1'b1) && n < 100) begin @(negedge clk); n++; end
    check("pre_rst_valid", {15'd0, out_valid}, 16'd1);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cpu_rst", {15'd0, cpu_rst}, 16'd1);
    check("midrst_cpu_clk", {15'd0, cpu_clk}, 16'd0);
    check("midrst_out_valid", {15'd0, out_valid}, 16'd0);
    check("midrst_running", {15'd0, running}, 16'd0);
    check("midrst_count", cycle_count, 16'd0);
    check("midrst_fetch_pc", {8'd0, fetch_pc}, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
